// File: rtl/card_click_decoder_pkg.sv
// Shared card geometry and address sizes, common to this decoder and the card position generator.
package card_click_decoder_pkg;

  localparam int COORD_W  = 12;
  localparam int ADDR_W   = 5;
  localparam int NUM_W    = 5;
  localparam int QUOT_W   = 3;

  localparam int ORIGIN_X = 104;
  localparam int ORIGIN_Y = 80;
  localparam int CARD_W   = 128;
  localparam int CARD_H   = 128;
  localparam int PITCH_X  = 144;
  localparam int PITCH_Y  = 144;
  localparam int COLS     = 6;
  localparam int ROWS_MAX = 4;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [NUM_W-1:0]   num_t;
  typedef logic [QUOT_W-1:0]  quot_t;

  // One bit wider than an address so an out-of-range slot never aliases a real card.
  function automatic logic [ADDR_W:0] cardAddr(input quot_t row, input quot_t col);
    return (ADDR_W+1)'(row) * (ADDR_W+1)'(COLS) + (ADDR_W+1)'(col);
  endfunction

endpackage

// File: rtl/card_click_decoder_if.sv
// Mouse/core-side signal bundle of the card click decoder.
interface card_click_decoder_if;
  import card_click_decoder_pkg::*;

  coord_t mouse_xpos;
  coord_t mouse_ypos;
  logic   mouse_left;
  logic   wait_for_click_en;
  num_t   num_of_cards;
  addr_t  card_clicked_address;
  addr_t  card_to_test_address;
  logic   card_pressed;
  logic   busy;

  modport master (
    output mouse_xpos, mouse_ypos, mouse_left, wait_for_click_en, num_of_cards,
    input  card_clicked_address, card_to_test_address, card_pressed, busy
  );

  modport slave (
    input  mouse_xpos, mouse_ypos, mouse_left, wait_for_click_en, num_of_cards,
    output card_clicked_address, card_to_test_address, card_pressed, busy
  );

endinterface

// File: rtl/card_click_decoder_pitch_divider.sv
// Iterative-subtraction quotient/remainder by a fixed pitch, one subtraction per step,
// flagging overflow when another subtraction is needed but the quotient is at its limit.
module card_click_decoder_pitch_divider
  import card_click_decoder_pkg::*;
#(
  parameter int PITCH = 144,
  parameter int LIMIT = 5
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  coord_t value_i,
  input  logic   step_i,
  output quot_t  quot_o,
  output coord_t rem_o,
  output logic   done_o,
  output logic   ovf_o
);

  coord_t rem_q, rem_d;
  quot_t  quot_q, quot_d;
  logic   geq;

  assign geq    = rem_q >= COORD_W'(PITCH);
  assign done_o = !geq;
  assign ovf_o  = geq && (quot_q == QUOT_W'(LIMIT));
  assign quot_o = quot_q;
  assign rem_o  = rem_q;

  always_comb begin
    rem_d  = rem_q;
    quot_d = quot_q;
    if (load_i) begin
      rem_d  = value_i;
      quot_d = '0;
    end else if (step_i && geq && !ovf_o) begin
      rem_d  = rem_q - COORD_W'(PITCH);
      quot_d = quot_q + QUOT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quot_q <= '0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
    end
  end

endmodule

// File: rtl/card_click_decoder.sv
// Turns a left-button press edge at pixel (x,y) into a card address plus a one-cycle
// card_pressed pulse, rejecting gaps, off-grid positions, unused slots and disabled windows.
module card_click_decoder
  import card_click_decoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  card_click_decoder_if.slave  bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DIV_X = 3'd1;
  localparam logic [2:0] DIV_Y = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] PULSE = 3'd4;

  logic [2:0]      state_q, state_d;
  logic            leftHist_q;
  addr_t           addr_q, addr_d;
  logic            pressed_q;
  logic            busy_q;

  logic            accept, inGrid, loadDiv, enable;
  quot_t           col, row;
  coord_t          xRem, yRem;
  logic            xDone, xOvf, yDone, yOvf;
  logic [ADDR_W:0] slotAddr;
  logic            hit;

  assign enable  = bus.wait_for_click_en;
  assign accept  = (state_q == IDLE) && enable && bus.mouse_left && !leftHist_q;
  assign inGrid  = (bus.mouse_xpos >= COORD_W'(ORIGIN_X)) && (bus.mouse_ypos >= COORD_W'(ORIGIN_Y));
  assign loadDiv = accept && inGrid;

  card_click_decoder_pitch_divider #(.PITCH(PITCH_X), .LIMIT(COLS - 1)) xDiv (
    .clk    (clk),
    .rst    (rst),
    .load_i (loadDiv),
    .value_i(bus.mouse_xpos - COORD_W'(ORIGIN_X)),
    .step_i ((state_q == DIV_X) && enable),
    .quot_o (col),
    .rem_o  (xRem),
    .done_o (xDone),
    .ovf_o  (xOvf)
  );

  card_click_decoder_pitch_divider #(.PITCH(PITCH_Y), .LIMIT(ROWS_MAX - 1)) yDiv (
    .clk    (clk),
    .rst    (rst),
    .load_i (loadDiv),
    .value_i(bus.mouse_ypos - COORD_W'(ORIGIN_Y)),
    .step_i ((state_q == DIV_Y) && enable),
    .quot_o (row),
    .rem_o  (yRem),
    .done_o (yDone),
    .ovf_o  (yOvf)
  );

  assign slotAddr = cardAddr(row, col);
  assign hit      = (xRem < COORD_W'(CARD_W)) && (yRem < COORD_W'(CARD_H))
                 && (slotAddr < {1'b0, bus.num_of_cards});

  // Dropping the click window aborts any decode in flight; a reached PULSE still completes.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE:  if (loadDiv) state_d = DIV_X;
      DIV_X: begin
        if (!enable || xOvf) state_d = IDLE;
        else if (xDone)      state_d = DIV_Y;
      end
      DIV_Y: begin
        if (!enable || yOvf) state_d = IDLE;
        else if (yDone)      state_d = CHECK;
      end
      CHECK: begin
        if (enable && hit) begin
          addr_d  = slotAddr[ADDR_W-1:0];
          state_d = PULSE;
        end else begin
          state_d = IDLE;
        end
      end
      PULSE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      leftHist_q <= 1'b0;
      addr_q     <= '0;
      pressed_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      leftHist_q <= bus.mouse_left;
      addr_q     <= addr_d;
      pressed_q  <= (state_d == PULSE);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign bus.card_clicked_address = addr_q;
  assign bus.card_to_test_address = addr_q;
  assign bus.card_pressed         = pressed_q;
  assign bus.busy                 = busy_q;

endmodule

// File: tb/tb_card_click_decoder.sv
// Directed and randomized clicks against a divide/modulo model of the card grid.
module tb_card_click_decoder;

  localparam int OX = 104, OY = 80, CW = 128, CH = 128, PX = 144, PY = 144;
  localparam int NCOLS = 6, NROWS = 4;

  logic clk;
  logic rst;
  card_click_decoder_if bus ();

  card_click_decoder dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int obsPulses, obsFirst, obsBusy;
  int obsAddr;
  int expAddr = 0;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic watch(input int n, input int releaseAt);
    for (int k = 0; k < n; k++) begin
      tick();
      if (bus.busy) obsBusy++;
      if (bus.card_pressed) begin
        if (obsPulses == 0) obsFirst = k;
        obsPulses++;
        obsAddr = int'(bus.card_to_test_address);
      end
      if (k == releaseAt) bus.mouse_left = 1'b0;
    end
  endtask

  task automatic press(input int x, input int y);
    bus.mouse_xpos = 12'(x);
    bus.mouse_ypos = 12'(y);
    bus.mouse_left = 1'b1;
    obsPulses = 0;
    obsFirst  = -1;
    obsBusy   = 0;
    obsAddr   = -1;
  endtask

  task automatic applyStimulus(input int x, input int y, input int num, input bit en, input int hold);
    bus.num_of_cards      = 5'(num);
    bus.wait_for_click_en = en;
    press(x, y);
    watch(hold + 20, hold - 1);
  endtask

  // Grid lookup by plain division: quotient picks the slot, remainder tells card from gap.
  function automatic void refModel(input int x, input int y, input int num,
                                   output bit hit, output int addr, output int lat, output int busyCycles);
    int dx, dy, col, row;
    hit = 0; addr = 0; lat = 0; busyCycles = 0;
    if (x < OX || y < OY) return;
    dx = x - OX; dy = y - OY;
    col = dx / PX; row = dy / PY;
    if (col >= NCOLS) begin busyCycles = NCOLS; return; end
    if (row >= NROWS) begin busyCycles = col + 1 + NROWS; return; end
    busyCycles = col + row + 3;
    if ((dx % PX) < CW && (dy % PY) < CH && (row * NCOLS + col) < num) begin
      hit = 1; addr = row * NCOLS + col; lat = col + row + 3; busyCycles++;
    end
  endfunction

  task automatic checkAgainstModel(input string tag, input int x, input int y, input int num, input int hold);
    bit hit;
    int addr, lat, busyCycles;
    refModel(x, y, num, hit, addr, lat, busyCycles);
    applyStimulus(x, y, num, 1'b1, hold);
    if (hit) expAddr = addr;
    checkOutput({tag, "_pulses"}, obsPulses, hit ? 1 : 0);
    if (hit) begin
      checkOutput({tag, "_latency"}, obsFirst, lat);
      checkOutput({tag, "_pulseAddr"}, obsAddr, addr);
    end
    checkOutput({tag, "_busy"}, obsBusy, busyCycles);
    checkOutput({tag, "_addr"}, int'(bus.card_clicked_address), expAddr);
    checkOutput({tag, "_testAddr"}, int'(bus.card_to_test_address), expAddr);
  endtask

  initial begin
    int rx, ry, rn;
    rst = 1'b1;
    bus.mouse_xpos = '0;
    bus.mouse_ypos = '0;
    bus.mouse_left = 1'b0;
    bus.wait_for_click_en = 1'b1;
    bus.num_of_cards = 5'd24;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checkOutput("reset_addr", int'(bus.card_clicked_address), 0);
    checkOutput("reset_testAddr", int'(bus.card_to_test_address), 0);
    checkOutput("reset_pressed", int'(bus.card_pressed), 0);
    checkOutput("reset_busy", int'(bus.busy), 0);

    checkAgainstModel("card0", 110, 90, 24, 1);
    checkAgainstModel("card23", 834, 522, 24, 1);
    checkAgainstModel("card23_num16", 834, 522, 16, 1);
    checkAgainstModel("gap", 234, 90, 24, 1);
    checkAgainstModel("leftOfOrigin", 50, 300, 24, 1);
    checkAgainstModel("hold100", 258, 234, 24, 100);

    $display("[TB] second press while busy");
    bus.num_of_cards = 5'd24;
    press(834, 522);
    watch(2, 0);
    bus.mouse_left = 1'b1;
    watch(20, 2);
    expAddr = 23;
    checkOutput("rePress_pulses", obsPulses, 1);
    checkOutput("rePress_addr", int'(bus.card_clicked_address), 23);

    checkAgainstModel("card7", 258, 234, 24, 1);

    $display("[TB] click window dropped in DIV_X");
    press(834, 522);
    watch(3, 0);
    bus.wait_for_click_en = 1'b0;
    watch(15, -1);
    checkOutput("abort_pulses", obsPulses, 0);
    checkOutput("abort_busy", int'(bus.busy), 0);
    checkOutput("abort_addr", int'(bus.card_clicked_address), 7);
    bus.wait_for_click_en = 1'b1;
    tick();

    $display("[TB] reset in DIV_Y");
    press(834, 522);
    watch(9, 0);
    checkOutput("rstMid_busyBefore", int'(bus.busy), 1);
    rst = 1'b1;
    tick();
    checkOutput("rstMid_addr", int'(bus.card_clicked_address), 0);
    checkOutput("rstMid_testAddr", int'(bus.card_to_test_address), 0);
    checkOutput("rstMid_pressed", int'(bus.card_pressed), 0);
    checkOutput("rstMid_busy", int'(bus.busy), 0);
    rst = 1'b0;
    expAddr = 0;
    obsPulses = 0;
    watch(15, -1);
    checkOutput("rstMid_pulsesAfter", obsPulses, 0);

    applyStimulus(258, 234, 24, 1'b0, 1);
    checkOutput("disabled_pulses", obsPulses, 0);
    checkOutput("disabled_busy", obsBusy, 0);
    checkOutput("disabled_addr", int'(bus.card_clicked_address), expAddr);

    for (int i = 0; i < 40; i++) begin
      rx = int'($urandom_range(1100, 0));
      ry = int'($urandom_range(750, 0));
      rn = int'($urandom_range(24, 1));
      checkAgainstModel($sformatf("rnd%0d", i), rx, ry, rn, int'($urandom_range(3, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/card_click_decoder.md
Name: card_click_decoder

Overview:
- Sits directly upstream of the game core. Converts raw mouse position and left-button state into the card-click inputs the core consumes: card_clicked_address, card_to_test_address and the card_pressed pulse.
- Detects a left-button press, then runs a small iterative-subtraction FSM to map pixel (x,y) onto the card grid. The grid geometry is the same one the card position generator uses.
- Rejects clicks that land in gaps, outside the grid, on unused slots, or outside the click window.

Parameters:
- ORIGIN_X, 104, x pixel of the top-left corner of card 0
- ORIGIN_Y, 80, y pixel of the top-left corner of card 0
- CARD_W, 128, card width in pixels
- CARD_H, 128, card height in pixels
- PITCH_X, 144, horizontal card-to-card pitch in pixels (CARD_W + gap)
- PITCH_Y, 144, vertical card-to-card pitch in pixels
- COLS, 6, cards per row
- ROWS_MAX, 4, maximum number of rows
- ADDR_W, 5, card address width; must equal the shared card address size
- NUM_W, 5, num_of_cards width; must equal the shared max-num size

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- mouse_xpos  in  12  mouse x in pixels
- mouse_ypos  in  12  mouse y in pixels
- mouse_left  in  1  left button level
- wait_for_click_en  in  1  core is accepting clicks
- num_of_cards  in  NUM_W  number of cards in play
- card_clicked_address  out  ADDR_W  address of the last valid clicked card
- card_to_test_address  out  ADDR_W  same value as card_clicked_address; drives the regfile read port
- card_pressed  out  1  one-cycle pulse marking a valid card click
- busy  out  1  high while the decode FSM is not in IDLE

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE.
  - card_clicked_address, card_to_test_address, card_pressed and busy are all 0.
  - The button history register is cleared to 0.
- Press edge: mouse_left is registered every cycle into left_d. A press edge is mouse_left=1 and left_d=0.
- Click acceptance: an edge is accepted only when the FSM is in IDLE and wait_for_click_en=1. Edges seen in any other state are dropped, not queued. A held button never repeats.
- IDLE: on an accepted edge, register x and y.
  - If x < ORIGIN_X or y < ORIGIN_Y, stay in IDLE (miss).
  - Otherwise load dx = x-ORIGIN_X, dy = y-ORIGIN_Y, col=0, row=0, and go to DIV_X.
- DIV_X (one step per cycle):
  - If dx >= PITCH_X and col = COLS-1: miss, go to IDLE.
  - Else if dx >= PITCH_X: dx -= PITCH_X, col++.
  - Else go to DIV_Y.
- DIV_Y: same rules as DIV_X, using dy, PITCH_Y, row and ROWS_MAX-1. On exit, go to CHECK.
- CHECK (one cycle):
  - addr = row*COLS + col, computed at ADDR_W+1 bits with no truncation.
  - Hit when dx < CARD_W and dy < CARD_H and addr < num_of_cards. num_of_cards is sampled in this cycle.
  - Hit: register addr into both address outputs and go to PULSE.
  - Miss: addresses hold their previous value; go to IDLE.
- PULSE: card_pressed=1 for exactly this one cycle, then go to IDLE. Because the address is updated one cycle before the pulse, the registered regfile read returns the card's colour aligned with card_pressed.
- Latency: edge sampled at clock edge T; card_pressed is high in the cycle after edge T + col + row + 3.
  - Card 0: pulse after T+3.
  - Worst case (col 5, row 3): pulse after T+11.
- Abort: if wait_for_click_en falls in DIV_X, DIV_Y or CHECK, go to IDLE with no pulse and no address update. A PULSE already reached still completes.
- Reset mid-operation: IDLE immediately; no pulse is issued afterwards.
- busy = (state != IDLE), registered.

Decomposition:
- The shared card macros header owns ADDR_W/NUM_W (the card address and max-num sizes) and the grid geometry constants (origin, card size, pitch, COLS, ROWS_MAX), so the position generator and this block cannot diverge.
- The FSM state encoding is local.
- One natural sub-module: pitch_divider. It is the iterative-subtraction quotient/remainder unit with limit-based overflow and is instantiated once per axis (x and y), run sequentially.

Test Plan:
- num_of_cards=24, click at (110,90) -> card_clicked_address=0, card_pressed high for 1 cycle after T+3, busy high for 4 cycles.
- num_of_cards=24, click at (834,522) -> col 5, row 3, address 23, pulse after T+11. Same click with num_of_cards=16 -> no pulse, address unchanged.
- Click in a gap at (234,90) (dx=130 ≥ CARD_W) or at (50,300) (left of the origin) -> no pulse, address unchanged, FSM back in IDLE.
- Hold mouse_left high for 100 cycles over card 7 -> exactly one pulse. A second press during busy -> ignored.
- Drop wait_for_click_en while in DIV_X, and separately assert rst during DIV_Y -> no pulse; with rst, all outputs are 0 the next cycle.
- Press with wait_for_click_en=0 -> FSM stays in IDLE, no activity.
